// File: rtl/qoa_spi_master_if.sv
// rtl/qoa_spi_master_if.sv - byte stream, receive and SPI pin bundle for qoa_spi_master
interface qoa_spi_master_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       chipsel;
    logic       mosi;
    logic       miso;

    modport master (
        input  tx_valid, tx_data, tx_last, miso,
        output tx_ready, rx_valid, rx_data, busy, sclk, chipsel, mosi
    );

    modport slave (
        output tx_valid, tx_data, tx_last, miso,
        input  tx_ready, rx_valid, rx_data, busy, sclk, chipsel, mosi
    );
endinterface

// File: rtl/qoa_spi_master.sv
// rtl/qoa_spi_master.sv - SPI mode-0 byte master; receive path only when QOA_SPI_RX_EN is defined
module qoa_spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    qoa_spi_master_if.master   bus
);
    localparam int DIV = (CLK_DIV < 1) ? 1 : CLK_DIV;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          last_q, last_d;
    logic          sclk_q, sclk_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          rdy_en_q;
    logic          tx_ready;
    logic          accept;
    logic          phase_end;

    // rdy_en_q keeps tx_ready low until the first clock edge after reset release
    assign tx_ready  = rdy_en_q && ((state_q == IDLE) || (state_q == HOLD));
    assign accept    = bus.tx_valid && tx_ready;
    assign phase_end = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            last_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
            last_q   <= last_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_sh_d = tx_sh_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    state_d = SHIFT_LO;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_sh_d = bus.tx_data;
                    last_d  = bus.tx_last;
                    cs_d    = 1'b0;
                    mosi_d  = bus.tx_data[7];
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = last_q ? GAP : HOLD;
                        cs_d    = last_q;
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 3'd1;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_ready = tx_ready;
    assign bus.busy     = (state_q != IDLE);
    assign bus.sclk     = sclk_q;
    assign bus.chipsel  = cs_q;
    assign bus.mosi     = mosi_q;

`ifdef QOA_SPI_RX_EN
    logic       rx_sample;
    logic       byte_done;
    logic [7:0] rx_sh_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    // miso is captured on the rising SCLK transition; the byte is published on the 8th fall
    assign rx_sample = (state_q == SHIFT_LO) && phase_end;
    assign byte_done = (state_q == SHIFT_HI) && phase_end && (bit_q == 3'd7);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (rx_sample) begin
                rx_sh_q <= {rx_sh_q[6:0], bus.miso};
            end
            if (byte_done) begin
                rx_data_q <= rx_sh_q;
            end
            rx_valid_q <= byte_done;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`else
    assign bus.rx_data  = 8'h00;
    assign bus.rx_valid = 1'b0;
`endif
endmodule

// File: doc/qoa_spi_master.md
QOA_SPI_MASTER -- requirements
Module: qoa_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: sys_clk cycles per SCLK half-period; values below 1 SHALL behave as 1.
REQ-002 SHALL have the single clock sys_clk (input, 1) and the asynchronous active-low reset sys_rst_n (input, 1) as its only clock and reset.
REQ-003 SHALL have port tx_valid  input  1  byte offered for transfer.
REQ-004 SHALL have port tx_ready  output  1  master can accept a byte this cycle.
REQ-005 SHALL have port tx_data  input  8  byte to shift out, MSB first.
REQ-006 SHALL have port tx_last  input  1  deselect after this byte; sampled with tx_data.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have port rx_data  output  8  byte received on miso, MSB first.
REQ-009 SHALL have port busy  output  1  high from byte accept until the post-deselect gap completes.
REQ-010 SHALL have port sclk  output  1  SPI clock, mode 0 (idles low).
REQ-011 SHALL have port chipsel  output  1  chip select, high = unselected.
REQ-012 SHALL have ports mosi  output  1  and  miso  input  1.

Function
REQ-013 SHALL use states IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP; SHIFT_LO/SHIFT_HI SHALL each last CLK_DIV cycles.
REQ-014 tx_ready SHALL be high in IDLE and HOLD only; a byte is accepted on a cycle with tx_valid and tx_ready both high.
REQ-015 On accept, chipsel SHALL go low (if high), mosi SHALL present tx_data[7] and the FSM SHALL enter SHIFT_LO on the next cycle.
REQ-016 SCLK SHALL rise on SHIFT_LO->SHIFT_HI; miso SHALL be sampled into the shift register on that same edge.
REQ-017 SCLK SHALL fall on SHIFT_HI->SHIFT_LO; mosi SHALL advance to the next lower bit on that same edge.
REQ-018 Each byte SHALL produce exactly 8 SCLK rising edges and take 16*CLK_DIV cycles from accept to the final falling edge.
REQ-019 After the 8th falling edge, rx_data SHALL update and rx_valid SHALL pulse high for exactly one cycle.
REQ-020 After the 8th falling edge, the FSM SHALL enter GAP when tx_last was 1, otherwise HOLD.
REQ-021 In HOLD, chipsel SHALL stay low and sclk low indefinitely until the next accept; an accepted byte SHALL start without deasserting chipsel.
REQ-022 GAP SHALL drive chipsel high for CLK_DIV cycles, then enter IDLE.
REQ-023 tx_valid outside IDLE/HOLD SHALL be ignored; tx_data/tx_last SHALL be captured only at accept.
REQ-024 busy SHALL be low only in IDLE.

Reset
REQ-025 sys_rst_n low SHALL immediately (asynchronously), including mid-byte, force: state IDLE, sclk 0, chipsel 1, mosi 0, tx_ready 0 while asserted, rx_valid 0, rx_data 0x00, busy 0.
REQ-026 tx_ready SHALL go high on the first sys_clk edge after reset release; no partial byte SHALL be reported.

Configuration
REQ-027 With QOA_SPI_RX_EN defined, receive behaves per REQ-016/REQ-019.
REQ-028 Without QOA_SPI_RX_EN, the miso shift register SHALL be omitted, rx_data SHALL be constant 0x00 and rx_valid constant 0; transmit timing SHALL be unchanged.

Verification
REQ-029 CLK_DIV=2, tx 0xA5 tx_last=1, miso model returns 0x3C -> mosi 1,0,1,0,0,1,0,1 on rising edges, 8 edges, rx_valid one pulse with rx_data=0x3C, chipsel high 2 cycles then busy low.
REQ-030 Back-to-back 0x12 (last=0) then 0x34 (last=1) offered in HOLD -> chipsel low continuously, 16 rising edges, two rx_valid pulses, single deselect.
REQ-031 0x55 last=0 with no follow-up for 50 cycles -> chipsel held low, sclk low, tx_ready high throughout; then 0xAA last=1 completes normally.
REQ-032 sys_rst_n low after 3rd rising edge -> same cycle sclk 0, chipsel 1, no rx_valid; post-reset 0x81 transfers correctly.
REQ-033 tx_valid held high during SHIFT with changing tx_data -> only accepted byte transmitted, no extra edges; CLK_DIV=1 variant gives 16-cycle bytes.
REQ-034 Build without QOA_SPI_RX_EN, tx 0xFF -> identical sclk/mosi/chipsel waveform, rx_valid never asserts, rx_data=0x00.
